// File: rtl/bmd_rx_engine.sv
// BMD receive engine: decodes single-DW memory reads/writes arriving on the
// 64-bit TRN receive interface. Writes become a one-cycle register-file strobe,
// reads become a completion request held until the TX engine reports it sent,
// and everything else is drained and flagged with drop_o.
module bmd_rx_engine #(
  parameter int BAR_SEL = 0,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       trn_rd,
  input  logic [7:0]        trn_rrem_n,
  input  logic              trn_rsof_n,
  input  logic              trn_reof_n,
  input  logic              trn_rsrc_rdy_n,
  input  logic              trn_rsrc_dsc_n,
  output logic              trn_rdst_rdy_n,
  input  logic [6:0]        trn_rbar_hit_n,
  output logic              req_compl_o,
  input  logic              compl_done_i,
  output logic [2:0]        req_tc_o,
  output logic              req_td_o,
  output logic              req_ep_o,
  output logic [1:0]        req_attr_o,
  output logic [9:0]        req_len_o,
  output logic [15:0]       req_rid_o,
  output logic [7:0]        req_tag_o,
  output logic [3:0]        req_be_o,
  output logic [10:0]       req_addr_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [3:0]        wr_be_o,
  output logic [31:0]       wr_data_o,
  output logic              drop_o
);

  typedef enum logic [2:0] {
    IDLE, MRD32_A, MRD64_A, MWR32_A, MWR64_A, MWR64_D, WAIT_CMPL, DISCARD
  } state_t;

  state_t state, state_nxt;

  logic        rdy_n_q;
  logic        wr_en_p1, drop_p1;
  logic        wr_go, drop_go, req_ld, hdr_ld, a64_ld;
  logic        accept, sof, eof, dsc, bar_hit;
  logic [31:0] dw0, dw1;
  state_t      dec_state;

  logic [2:0]        hdr_tc;
  logic              hdr_td, hdr_ep;
  logic [1:0]        hdr_attr;
  logic [9:0]        hdr_len;
  logic [15:0]       hdr_rid;
  logic [7:0]        hdr_tag;
  logic [3:0]        hdr_fbe;
  logic [ADDR_W-1:0] a64_q;

  // Remaining fields (reserved header bits, upper address bits, other BARs,
  // remainder) carry nothing this engine acts on.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, trn_rrem_n, trn_rd, trn_rbar_hit_n};

  // Only single-DW, BAR-hitting memory requests are serviced.
  function automatic state_t decode_hdr(input logic [1:0] fmt, input logic [4:0] typ,
                                        input logic [9:0] len, input logic hit);
    state_t s;
    s = DISCARD;
    if (hit && (len == 10'd1) && (typ == 5'd0)) begin
      case (fmt)
        2'b00: s = MRD32_A;
        2'b01: s = MRD64_A;
        2'b10: s = MWR32_A;
        2'b11: s = MWR64_A;
      endcase
    end
    return s;
  endfunction

  // Wire data is big-endian per byte; the register file wants little-endian.
  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  assign dw0       = trn_rd[63:32];
  assign dw1       = trn_rd[31:0];
  assign accept    = !trn_rsrc_rdy_n && !rdy_n_q;
  assign sof       = accept && !trn_rsof_n;
  assign eof       = accept && !trn_reof_n;
  assign dsc       = !trn_rsrc_dsc_n;
  assign bar_hit   = !trn_rbar_hit_n[BAR_SEL];
  assign dec_state = decode_hdr(dw0[30:29], dw0[28:24], dw0[9:0], bar_hit);

  // State register plus registered control strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rdy_n_q  <= 1'b1;
      wr_en_p1 <= 1'b0;
      drop_p1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rdy_n_q  <= (state_nxt == WAIT_CMPL);
      wr_en_p1 <= wr_go;
      drop_p1  <= drop_go;
    end
  end

  // Next-state and per-beat control decode.
  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    drop_go   = 1'b0;
    req_ld    = 1'b0;
    hdr_ld    = 1'b0;
    a64_ld    = 1'b0;
    case (state)
      IDLE: begin
        if (sof) begin
          hdr_ld = 1'b1;
          if (eof) drop_go = 1'b1;
          else     state_nxt = dec_state;
        end
      end
      WAIT_CMPL: begin
        if (compl_done_i) state_nxt = IDLE;
      end
      default: begin
        if (dsc) begin
          drop_go   = 1'b1;
          state_nxt = IDLE;
        end else if (sof) begin
          // A new header cuts the current TLP short; decode it in place.
          drop_go   = 1'b1;
          hdr_ld    = 1'b1;
          state_nxt = eof ? IDLE : dec_state;
        end else if (accept) begin
          case (state)
            MRD32_A, MRD64_A: begin
              if (eof) begin
                req_ld    = 1'b1;
                state_nxt = WAIT_CMPL;
              end else begin
                state_nxt = DISCARD;
              end
            end
            MWR32_A, MWR64_D: begin
              if (eof) begin
                wr_go     = 1'b1;
                state_nxt = IDLE;
              end else begin
                state_nxt = DISCARD;
              end
            end
            MWR64_A: begin
              a64_ld = 1'b1;
              if (eof) begin
                drop_go   = 1'b1;
                state_nxt = IDLE;
              end else begin
                state_nxt = MWR64_D;
              end
            end
            default: begin
              if (eof) begin
                drop_go   = 1'b1;
                state_nxt = IDLE;
              end
            end
          endcase
        end
      end
    endcase
  end

  // Output decode.
  always_comb begin
    req_compl_o    = (state == WAIT_CMPL);
    trn_rdst_rdy_n = rdy_n_q;
    wr_en_o        = wr_en_p1;
    drop_o         = drop_p1;
  end

  // Header fields captured on every decoded SOF beat.
  always_ff @(posedge clk) begin
    if (hdr_ld) begin
      hdr_tc   <= dw0[22:20];
      hdr_td   <= dw0[15];
      hdr_ep   <= dw0[14];
      hdr_attr <= dw0[13:12];
      hdr_len  <= dw0[9:0];
      hdr_rid  <= dw1[31:16];
      hdr_tag  <= dw1[15:8];
      hdr_fbe  <= dw1[3:0];
    end
    if (a64_ld) a64_q <= dw1[ADDR_W+1:2];
  end

  // Completion request fields, frozen while the request is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_tc_o   <= '0;
      req_td_o   <= 1'b0;
      req_ep_o   <= 1'b0;
      req_attr_o <= '0;
      req_len_o  <= '0;
      req_rid_o  <= '0;
      req_tag_o  <= '0;
      req_be_o   <= '0;
      req_addr_o <= '0;
    end else if (req_ld) begin
      req_tc_o   <= hdr_tc;
      req_td_o   <= hdr_td;
      req_ep_o   <= hdr_ep;
      req_attr_o <= hdr_attr;
      req_len_o  <= hdr_len;
      req_rid_o  <= hdr_rid;
      req_tag_o  <= hdr_tag;
      req_be_o   <= hdr_fbe;
      req_addr_o <= (state == MRD32_A) ? dw0[12:2] : dw1[12:2];
    end
  end

  // Write port fields, held after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_o <= '0;
      wr_be_o   <= '0;
      wr_data_o <= '0;
    end else if (wr_go) begin
      wr_addr_o <= (state == MWR32_A) ? dw0[ADDR_W+1:2] : a64_q;
      wr_be_o   <= hdr_fbe;
      wr_data_o <= byte_swap((state == MWR32_A) ? dw1 : dw0);
    end
  end

endmodule

// File: tb/tb_bmd_rx_engine.sv
// Scoreboard bench for bmd_rx_engine: stimulus pushes expected write, request
// and drop events; a monitor pops and compares them as the DUT produces them.
module tb_bmd_rx_engine;
  localparam int ADDR_W = 7;
  localparam int K_WR = 1, K_REQ = 2, K_DROP = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic [63:0] trn_rd = '0;
  logic [7:0]  trn_rrem_n = '0;
  logic trn_rsof_n = 1'b1, trn_reof_n = 1'b1, trn_rsrc_rdy_n = 1'b1, trn_rsrc_dsc_n = 1'b1;
  logic trn_rdst_rdy_n;
  logic [6:0] trn_rbar_hit_n = 7'h7E;
  logic req_compl_o, compl_done_i = 1'b0;
  logic [2:0] req_tc_o;
  logic req_td_o, req_ep_o;
  logic [1:0] req_attr_o;
  logic [9:0] req_len_o;
  logic [15:0] req_rid_o;
  logic [7:0] req_tag_o;
  logic [3:0] req_be_o;
  logic [10:0] req_addr_o;
  logic wr_en_o, drop_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [3:0] wr_be_o;
  logic [31:0] wr_data_o;

  bmd_rx_engine #(.BAR_SEL(0), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
    .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rdst_rdy_n(trn_rdst_rdy_n),
    .trn_rbar_hit_n(trn_rbar_hit_n), .req_compl_o(req_compl_o), .compl_done_i(compl_done_i),
    .req_tc_o(req_tc_o), .req_td_o(req_td_o), .req_ep_o(req_ep_o), .req_attr_o(req_attr_o),
    .req_len_o(req_len_o), .req_rid_o(req_rid_o), .req_tag_o(req_tag_o), .req_be_o(req_be_o),
    .req_addr_o(req_addr_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_be_o(wr_be_o),
    .wr_data_o(wr_data_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } evt_t;
  evt_t exp_q[$];

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] x);
    evt_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.c = x;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind);
    int idx;
    evt_t e;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i].kind == kind) idx = i;
    if (idx < 0) begin
      check("unexpected_event_kind", kind, 0);
    end else begin
      e = exp_q[idx];
      exp_q.delete(idx);
      check("event_cycle", cyc, e.cyc);
      if (kind == K_WR) begin
        check("wr_addr", wr_addr_o, e.a);
        check("wr_data", wr_data_o, e.b);
        check("wr_be", wr_be_o, e.c);
      end else if (kind == K_REQ) begin
        check("req_addr", req_addr_o, e.a);
        check("req_rid_tag", {req_rid_o, req_tag_o}, e.b);
        check("req_hdr", {req_tc_o, req_td_o, req_ep_o, req_attr_o, req_be_o, req_len_o}, e.c);
      end
    end
  endtask

  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (wr_en_o === 1'b1) pop_check(K_WR);
    if (req_compl_o === 1'b1 && req_prev !== 1'b1) pop_check(K_REQ);
    if (drop_o === 1'b1) pop_check(K_DROP);
    req_prev = req_compl_o;
  end

  task automatic idle();
    trn_rsrc_rdy_n = 1'b1; trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_dsc_n = 1'b1;
  endtask

  // Present one beat and wait until it is taken; acc is the cycle number seen
  // just after the accepting edge, stalled says the DUT held it off.
  task automatic send(input logic [63:0] d, input logic [7:0] rem, input bit s, input bit e,
                      input bit ds, output int acc, output bit stalled);
    bit ok;
    trn_rd = d; trn_rrem_n = rem; trn_rsof_n = !s; trn_reof_n = !e;
    trn_rsrc_dsc_n = !ds; trn_rsrc_rdy_n = 1'b0;
    acc = -1; stalled = 1'b0;
    for (int i = 0; i < 100 && acc < 0; i++) begin
      ok = (trn_rdst_rdy_n == 1'b0) || ds;
      @(posedge clk); #1;
      if (ok) acc = cyc; else stalled = 1'b1;
    end
    if (acc < 0) check("beat_accept_timeout", 0, 1);
  endtask

  localparam logic [31:0] HDR_RD = 32'h0050_A001;   // tc=5 td=1 attr=2 len=1
  localparam logic [21:0] REQ_C  = {3'b101, 1'b1, 1'b0, 2'b10, 4'hF, 10'd1};

  task automatic mrd(input bit is64, input logic [31:0] addr, input logic [7:0] tag,
                     output int acc_h);
    int a; bit st;
    logic [31:0] h;
    h = is64 ? (HDR_RD | 32'h2000_0000) : HDR_RD;
    send({h, 16'h0100, tag, 8'h0F}, 8'h00, 1, 0, 0, acc_h, st);
    check("mrd_hdr_no_stall", st, 0);
    send(is64 ? {32'h0, addr} : {addr, 32'h0}, is64 ? 8'h00 : 8'h0F, 0, 1, 0, a, st);
    idle();
    push(K_REQ, a, {21'b0, addr[12:2]}, {16'h0100, tag}, {10'b0, REQ_C});
  endtask

  task automatic complete(input int n);
    for (int i = 0; i < n; i++) begin
      check("req_compl_held", req_compl_o, 1);
      check("dst_rdy_held_off", trn_rdst_rdy_n, 1);
      @(posedge clk); #1;
    end
    compl_done_i = 1'b1;
    @(posedge clk); #1;
    compl_done_i = 1'b0;
    check("req_compl_cleared", req_compl_o, 0);
    check("dst_rdy_released", trn_rdst_rdy_n, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a1, a3, ah, dcyc;
    bit st, st1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dst_rdy_n", trn_rdst_rdy_n, 1);
    check("rst_req_compl", req_compl_o, 0);
    check("rst_wr_en", wr_en_o, 0);
    check("rst_drop", drop_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rst_req_addr", req_addr_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("dst_rdy_after_rst", trn_rdst_rdy_n, 0);

    // MRd32 addr 0x10, completion 5 cycles later
    mrd(0, 32'h0000_0010, 8'h2A, ah);
    complete(5);

    // MWr32 addr 0x8 data 0x11223344
    send({32'h4000_0001, 32'h0000_000F}, 8'h00, 1, 0, 0, a, st);
    send({32'h0000_0008, 32'h1122_3344}, 8'h00, 0, 1, 0, a, st);
    idle();
    push(K_WR, a, 32'd2, 32'h4433_2211, 32'hF);
    repeat (3) @(posedge clk);
    #1;
    check("wr_data_holds", wr_data_o, 32'h4433_2211);

    // MWr64 addr 0x1_0000000C data 0xAABBCCDD
    send({32'h6000_0001, 32'h0000_000F}, 8'h00, 1, 0, 0, a, st);
    send({32'h0000_0001, 32'h0000_000C}, 8'h00, 0, 0, 0, a, st);
    send({32'hAABB_CCDD, 32'h0}, 8'h0F, 0, 1, 0, a, st);
    idle();
    push(K_WR, a, 32'd3, 32'hDDCC_BBAA, 32'hF);
    repeat (2) @(posedge clk);
    #1;

    // MRd32 with len=2, then with BAR miss: both dropped, never stalled
    send({32'h0000_0002, 32'h0100_2A0F}, 8'h00, 1, 0, 0, a, st);
    check("len2_no_stall", st, 0);
    send({32'h0000_0010, 32'h0}, 8'h0F, 0, 1, 0, a, st);
    check("len2_eof_no_stall", st, 0);
    idle();
    push(K_DROP, a, 0, 0, 0);
    trn_rbar_hit_n = 7'h7F;
    send({32'h0000_0001, 32'h0100_2A0F}, 8'h00, 1, 0, 0, a, st);
    check("miss_no_stall", st, 0);
    send({32'h0000_0010, 32'h0}, 8'h0F, 0, 1, 0, a, st);
    idle();
    push(K_DROP, a, 0, 0, 0);
    trn_rbar_hit_n = 7'h7E;
    repeat (2) @(posedge clk);
    #1;
    check("dst_rdy_after_drops", trn_rdst_rdy_n, 0);

    // MRd64 low address 0x40
    mrd(1, 32'h0000_0040, 8'h11, ah);
    complete(2);

    // Completion TLP arriving while a read is outstanding
    mrd(0, 32'h0000_0020, 8'h33, ah);
    dcyc = 0;
    fork
      begin
        send({32'h4A00_0001, 32'h0}, 8'h00, 1, 0, 0, a1, st1);
        send(64'h0, 8'h00, 0, 0, 0, a, st);
        send(64'h0, 8'h0F, 0, 1, 0, a3, st);
        push(K_DROP, a3, 0, 0, 0);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        compl_done_i = 1'b1;
        @(posedge clk); #1;
        dcyc = cyc;
        compl_done_i = 1'b0;
      end
    join
    check("cpl_stalled", st1, 1);
    check("cpl_accept_after_done", a1, dcyc + 1);

    // Discontinue on beat 2 of MWr32, then a normal read
    send({32'h4000_0001, 32'h0000_000F}, 8'h00, 1, 0, 0, a, st);
    send({32'h0000_0008, 32'hDEAD_BEEF}, 8'h00, 0, 1, 1, a, st);
    idle();
    push(K_DROP, a, 0, 0, 0);
    @(posedge clk); #1;
    mrd(0, 32'h0000_003C, 8'h44, ah);
    complete(1);

    // New SOF in the middle of an MWr32 aborts it and is decoded as a read
    send({32'h4000_0001, 32'h0000_000F}, 8'h00, 1, 0, 0, a, st);
    push(K_DROP, cyc + 1, 0, 0, 0);
    mrd(0, 32'h0000_0018, 8'h66, ah);
    check("resync_hdr_cycle", ah, a + 1);
    complete(2);

    // compl_done outside WAIT_CMPL is ignored
    compl_done_i = 1'b1;
    @(posedge clk); #1;
    compl_done_i = 1'b0;
    check("stray_done_req", req_compl_o, 0);
    check("stray_done_rdy", trn_rdst_rdy_n, 0);

    // Reset while a completion is pending
    mrd(0, 32'h0000_0004, 8'h55, ah);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wait_req_compl", req_compl_o, 0);
    check("rst_wait_dst_rdy", trn_rdst_rdy_n, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_wait_release_rdy", trn_rdst_rdy_n, 0);
    check("rst_wait_release_req", req_compl_o, 0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bmd_rx_engine.md
Name: bmd_rx_engine

Overview:
- Receive-side counterpart of the BMD TX engine.
- Accepts inbound TLPs from the PCIe core's 64-bit TRN receive interface (trn_r*) and decodes single-DW memory reads and writes that hit the selected BAR.
- Memory writes go to the local register file as a one-cycle write strobe.
- Memory reads become a completion request (req_compl/req_* fields) to the TX engine, held until compl_done; all other TLPs are drained and flagged.

Parameters:
- BAR_SEL, 0, index into trn_rbar_hit_n that must be low for a request to be accepted.
- ADDR_W, 7, width of wr_addr_o (DW address, taken from address bits [ADDR_W+1:2]).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- trn_rd  in  64  TLP data; first DW of each beat in [63:32].
- trn_rrem_n  in  8  8'h00 = both DWs valid; 8'h0F = only [63:32] valid.
- trn_rsof_n  in  1  start of TLP, active-low.
- trn_reof_n  in  1  end of TLP, active-low.
- trn_rsrc_rdy_n  in  1  source valid, active-low.
- trn_rsrc_dsc_n  in  1  source discontinue, active-low.
- trn_rdst_rdy_n  out  1  destination ready, active-low.
- trn_rbar_hit_n  in  7  BAR hit vector, active-low.
- req_compl_o  out  1  completion request to TX engine.
- compl_done_i  in  1  completion sent, from TX engine.
- req_tc_o  out  3  TC captured from the MRd header.
- req_td_o  out  1  TD captured from the MRd header.
- req_ep_o  out  1  EP captured from the MRd header.
- req_attr_o  out  2  attribute bits captured from the MRd header.
- req_len_o  out  10  length field captured from the MRd header.
- req_rid_o  out  16  requester ID.
- req_tag_o  out  8  tag.
- req_be_o  out  4  first-DW byte enables.
- req_addr_o  out  11  address bits [12:2].
- wr_en_o  out  1  register write strobe.
- wr_addr_o  out  ADDR_W  write DW address.
- wr_be_o  out  4  write byte enables (first DW BE).
- wr_data_o  out  32  write data, byte-swapped to little-endian.
- drop_o  out  1  one-cycle pulse when a TLP is discarded or aborted.

Behaviour:
- Beat accepted: trn_rsrc_rdy_n=0 and trn_rdst_rdy_n=0 on a rising clk.
- Header beat 1 fields:
  - DW0 = trn_rd[63:32]: fmt [30:29], type [28:24], tc [22:20], td [15], ep [14], attr [13:12], len [9:0].
  - DW1 = trn_rd[31:0]: rid [31:16], tag [15:8], fbe [3:0].
- Reset: all outputs 0, except trn_rdst_rdy_n=1. The state machine goes to IDLE. trn_rdst_rdy_n=0 on the first cycle after rst deasserts.
- States: IDLE, MRD32_A, MRD64_A, MWR32_A, MWR64_A, MWR64_D, WAIT_CMPL, DISCARD.
- Decode on an accepted SOF beat in IDLE. A request is valid only if len==1 and trn_rbar_hit_n[BAR_SEL]==0.
  - fmt/type 00/00000 (MRd32) -> MRD32_A.
  - 01/00000 (MRd64) -> MRD64_A.
  - 10/00000 (MWr32) -> MWR32_A.
  - 11/00000 (MWr64) -> MWR64_A.
  - Anything else, or an invalid request -> DISCARD.
  - If the SOF beat also carries EOF, return to IDLE and pulse drop_o.
- MRD32_A: address = beat2[63:32].
- MRD64_A: address = beat2[31:0]; the upper DW is ignored.
- On the EOF beat of an MRd: latch the req_* fields and go to WAIT_CMPL.
  - req_compl_o=1 from the next cycle and held until compl_done_i is sampled 1.
  - trn_rdst_rdy_n=1 throughout WAIT_CMPL; req_* fields are stable while req_compl_o=1.
  - The cycle after compl_done_i: req_compl_o=0, trn_rdst_rdy_n=0, state IDLE.
  - compl_done_i outside WAIT_CMPL is ignored.
- MWR32_A: address = beat2[63:32], data = beat2[31:0].
- MWR64_A then MWR64_D: address = beat2[31:0], data = beat3[63:32].
- MWr outputs:
  - wr_en_o pulses for exactly one cycle, the cycle after the data beat is accepted.
  - wr_addr_o, wr_be_o and wr_data_o are valid during that pulse and hold afterwards.
  - Byte swap: wr_data_o = {d[7:0], d[15:8], d[23:16], d[31:24]}.
  - MWr never deasserts trn_rdst_rdy_n.
- DISCARD: consume beats until an accepted EOF, pulse drop_o the next cycle, then go to IDLE.
- trn_rsrc_dsc_n=0 in any non-IDLE receive state:
  - Abort to IDLE immediately.
  - No wr_en_o and no req_compl_o are issued.
  - drop_o pulses the next cycle.
- Unexpected SOF in a mid-TLP state: pulse drop_o for the old TLP and decode the new header as if in IDLE.
- rst while in WAIT_CMPL: req_compl_o cleared, and the pending completion is lost.

Test Plan:
- MRd32 len=1, addr 0x00000010, rid 0x0100, tag 0x2A, fbe F, hit_n[0]=0, compl_done_i pulsed 5 cycles later:
  - req_compl_o rises 1 cycle after beat 2, with req_addr_o=0x004, req_tag_o=0x2A, req_rid_o=0x0100.
  - trn_rdst_rdy_n=1 until the cycle after compl_done_i.
- MWr32 addr 0x00000008, data 0x11223344, fbe F: single wr_en_o pulse with wr_addr_o=2, wr_data_o=0x44332211, wr_be_o=F, no req_compl_o.
- MWr64 addr hi 0x00000001, lo 0x0000000C, data 0xAABBCCDD in beat 3: wr_addr_o=3, wr_data_o=0xDDCCBBAA, one pulse after beat 3.
- MRd32 with len=2, then MRd32 with hit_n[0]=1: two drop_o pulses, no req_compl_o, trn_rdst_rdy_n stays 0.
- Completion TLP (fmt/type 10/01010) over 3 beats with trn_rdst_rdy_n stalled by a WAIT_CMPL: drained only after compl_done_i, then drop_o=1 for one cycle.
- trn_rsrc_dsc_n=0 on beat 2 of an MWr32 -> no wr_en_o, drop_o pulse, next MRd32 decoded normally. rst asserted in WAIT_CMPL -> req_compl_o=0 next cycle and trn_rdst_rdy_n=0 after release.
